// File: rtl/hazard_pkg.sv
// hazard_pkg: register-file geometry and default long-latency capacity for the interlock
package hazard_pkg;
    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS = 32;
    localparam int MAX_LONG_DEF = 4;
endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: pending-writeback bit per register plus outstanding long-op counter
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int MAX_LONG = MAX_LONG_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en,
    input  logic [REG_IDX_W-1:0] set_idx,
    input  logic                 clr_en,
    input  logic [REG_IDX_W-1:0] clr_idx,
    output logic [NUM_REGS-1:0]  pending,
    output logic                 long_full
);
    localparam int CW = $clog2(MAX_LONG + 1);
    logic [CW-1:0] cnt;
    logic [NUM_REGS-1:0] pending_nxt;
    always_comb begin
        pending_nxt = pending;
        if (clr_en) pending_nxt[clr_idx] = 1'b0;
        // set after clear so a same-index collision keeps the new owner
        if (set_en) pending_nxt[set_idx] = 1'b1;
        pending_nxt[0] = 1'b0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            cnt     <= '0;
        end else begin
            pending <= pending_nxt;
            if (set_en && !clr_en && cnt != CW'(MAX_LONG)) cnt <= cnt + CW'(1);
            else if (clr_en && !set_en && cnt != '0) cnt <= cnt - CW'(1);
        end
    end
    assign long_full = cnt == CW'(MAX_LONG);
endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: ID/EX interlock for load-use, long-latency RAW/WAW, capacity and branch flush; HAZARD_PERF_EN adds stall/flush cycle counters
module hazard_stall_unit
    import hazard_pkg::*;
#(
`ifdef HAZARD_PERF_EN
    parameter int XLEN = 32,
`endif
    parameter int MAX_LONG = MAX_LONG_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic                 id_long,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 branch_taken,
    input  logic                 lu_done,
    input  logic [REG_IDX_W-1:0] lu_rd,
    output logic                 stall_if,
    output logic                 stall_id,
    output logic                 flush_id,
    output logic                 flush_ex,
    output logic [NUM_REGS-1:0]  pending,
    output logic                 long_full
`ifdef HAZARD_PERF_EN
    ,
    output logic [XLEN-1:0]      perf_stall_cycles,
    output logic [XLEN-1:0]      perf_flush_cycles
`endif
);
    logic lu_hz, raw_hz, waw_hz, cap_hz, hz, issue;
    always_comb begin
        lu_hz    = ex_mem_read && ex_rd != '0 &&
                   ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
        raw_hz   = (id_use_rs1 && pending[id_rs1]) || (id_use_rs2 && pending[id_rs2]);
        waw_hz   = id_rd != '0 && pending[id_rd];
        cap_hz   = id_long && long_full;
        hz       = id_valid && (lu_hz || raw_hz || waw_hz || cap_hz);
        issue    = id_valid && !hz && !branch_taken;
        stall_if = hz && !branch_taken;
        stall_id = stall_if;
        flush_id = branch_taken;
        flush_ex = branch_taken || hz;
    end
    hazard_scoreboard #(.MAX_LONG(MAX_LONG)) u_sb (
        .clk       (clk),
        .rst       (rst),
        .set_en    (issue && id_long),
        .set_idx   (id_rd),
        .clr_en    (lu_done),
        .clr_idx   (lu_rd),
        .pending   (pending),
        .long_full (long_full)
    );
`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_flush_cycles <= '0;
        end else begin
            if (stall_id) perf_stall_cycles <= perf_stall_cycles + XLEN'(1);
            if (branch_taken) perf_flush_cycles <= perf_flush_cycles + XLEN'(1);
        end
    end
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed checks of the interlock with MAX_LONG=2 plus a standalone scoreboard instance
module tb_hazard_stall_unit;
    logic clk = 1'b0, rst;
    logic id_valid, id_use_rs1, id_use_rs2, id_long, ex_mem_read, branch_taken, lu_done;
    logic [4:0] id_rs1, id_rs2, id_rd, ex_rd, lu_rd;
    logic stall_if, stall_id, flush_id, flush_ex, long_full;
    logic [31:0] pending;
    logic sb_set, sb_clr, sb_full;
    logic [4:0] sb_set_idx, sb_clr_idx;
    logic [31:0] sb_pending;
    int checks = 0, errors = 0;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cycles, perf_flush_cycles;
`endif

    always #5 clk = ~clk;

    hazard_stall_unit #(.MAX_LONG(2)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_long(id_long),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .branch_taken(branch_taken),
        .lu_done(lu_done), .lu_rd(lu_rd), .stall_if(stall_if), .stall_id(stall_id),
        .flush_id(flush_id), .flush_ex(flush_ex), .pending(pending), .long_full(long_full)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cycles(perf_stall_cycles), .perf_flush_cycles(perf_flush_cycles)
`endif
    );

    hazard_scoreboard #(.MAX_LONG(2)) u_sb (
        .clk(clk), .rst(rst), .set_en(sb_set), .set_idx(sb_set_idx),
        .clr_en(sb_clr), .clr_idx(sb_clr_idx), .pending(sb_pending), .long_full(sb_full)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {id_valid, id_use_rs1, id_use_rs2, id_long, ex_mem_read, branch_taken, lu_done} = '0;
        {id_rs1, id_rs2, id_rd, ex_rd, lu_rd} = '0;
    endtask

    task automatic instr(input logic lng, input logic [4:0] rd, input logic u1, input logic [4:0] rs1);
        id_valid = 1'b1; id_long = lng; id_rd = rd; id_use_rs1 = u1; id_rs1 = rs1;
        id_use_rs2 = 1'b0; id_rs2 = '0;
    endtask

    function automatic logic [31:0] ctl();
        return {28'b0, stall_if, stall_id, flush_id, flush_ex};
    endfunction

    localparam logic [31:0] STALL = 32'hD, FLUSH = 32'h3, NONE = 32'h0;

    initial begin
        idle();
        {sb_set, sb_clr, sb_set_idx, sb_clr_idx} = '0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("reset_pending", pending, 0);
        check("reset_full", {31'b0, long_full}, 0);
        check("reset_ctl", ctl(), NONE);

        ex_mem_read = 1'b1; ex_rd = 5'd5;
        instr(1'b0, 5'd6, 1'b1, 5'd5); #1;
        check("loaduse_rs1", ctl(), STALL);
        ex_rd = 5'd0; id_rs1 = 5'd0; #1;
        check("loaduse_x0", ctl(), NONE);
        ex_rd = 5'd5; id_use_rs1 = 1'b0; id_use_rs2 = 1'b1; id_rs2 = 5'd5; #1;
        check("loaduse_rs2", ctl(), STALL);
        id_use_rs2 = 1'b0; id_rs1 = 5'd5; #1;
        check("loaduse_unused_src", ctl(), NONE);
        id_use_rs1 = 1'b1; id_valid = 1'b0; #1;
        check("loaduse_invalid", ctl(), NONE);

        idle();
        instr(1'b1, 5'd7, 1'b0, 5'd0); #1;
        check("long_issue_ctl", ctl(), NONE);
        tick();
        check("long_pending7", pending, 32'h80);
        instr(1'b0, 5'd10, 1'b1, 5'd7); #1;
        check("raw_stall0", ctl(), STALL);
        tick(); tick();
        check("raw_stall2", ctl(), STALL);
        lu_done = 1'b1; lu_rd = 5'd7; #1;
        check("raw_stall_strobe", ctl(), STALL);
        tick();
        lu_done = 1'b0; #1;
        check("raw_release", ctl(), NONE);
        check("raw_pending_clr", pending, 0);
        tick();

        instr(1'b1, 5'd9, 1'b0, 5'd0);
        tick();
        check("waw_pending9", pending, 32'h200);
        lu_done = 1'b1; lu_rd = 5'd9; #1;
        check("waw_stall", ctl(), STALL);
        tick();
        idle(); #1;
        check("waw_no_set", pending, 0);
        check("waw_cnt0", {31'b0, long_full}, 0);

        sb_set = 1'b1; sb_set_idx = 5'd9;
        tick();
        check("sb_set9", sb_pending, 32'h200);
        sb_clr = 1'b1; sb_clr_idx = 5'd9;
        tick();
        check("sb_setwins", sb_pending, 32'h200);
        check("sb_cnt_hold", {31'b0, sb_full}, 0);
        sb_clr = 1'b0; sb_set_idx = 5'd4;
        tick();
        check("sb_full2", {31'b0, sb_full}, 1);
        sb_set = 1'b0; sb_clr = 1'b1; sb_clr_idx = 5'd20;
        tick();
        sb_clr = 1'b0;
        check("sb_spurious_bits", sb_pending, 32'h210);
        check("sb_spurious_cnt", {31'b0, sb_full}, 0);

        instr(1'b1, 5'd3, 1'b0, 5'd0);
        tick();
        instr(1'b1, 5'd4, 1'b0, 5'd0);
        tick();
        check("cap_full", {31'b0, long_full}, 1);
        check("cap_pending", pending, 32'h18);
        instr(1'b1, 5'd8, 1'b0, 5'd0); #1;
        check("cap_stall", ctl(), STALL);
        tick();
        check("cap_stall_hold", ctl(), STALL);
        instr(1'b0, 5'd8, 1'b1, 5'd1); #1;
        check("cap_nonlong_issue", ctl(), NONE);
        instr(1'b1, 5'd8, 1'b0, 5'd0);
        lu_done = 1'b1; lu_rd = 5'd3; #1;
        check("cap_stall_strobe", ctl(), STALL);
        tick();
        lu_done = 1'b0; #1;
        check("cap_release_full", {31'b0, long_full}, 0);
        check("cap_release_ctl", ctl(), NONE);
        tick();
        check("cap_issue8", pending, 32'h110);
        check("cap_full_again", {31'b0, long_full}, 1);

        idle();
        lu_done = 1'b1; lu_rd = 5'd4;
        tick();
        idle();
        ex_mem_read = 1'b1; ex_rd = 5'd2; branch_taken = 1'b1;
        instr(1'b1, 5'd15, 1'b1, 5'd2); #1;
        check("br_priority", ctl(), FLUSH);
        tick();
        idle(); #1;
        check("br_no_set", pending, 32'h100);
        check("br_cnt1", {31'b0, long_full}, 0);

        instr(1'b1, 5'd3, 1'b0, 5'd0);
        tick();
        check("mid_full", {31'b0, long_full}, 1);
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        check("mid_rst_pending", pending, 0);
        check("mid_rst_full", {31'b0, long_full}, 0);
`ifdef HAZARD_PERF_EN
        check("perf_stall_rst", perf_stall_cycles, 0);
        check("perf_flush_rst", perf_flush_cycles, 0);
        ex_mem_read = 1'b1; ex_rd = 5'd5;
        instr(1'b0, 5'd6, 1'b1, 5'd5);
        tick(); tick(); tick();
        check("perf_stall3", perf_stall_cycles, 3);
        idle(); branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0;
        check("perf_flush1", perf_flush_cycles, 1);
        check("perf_stall_hold", perf_stall_cycles, 3);
`endif
        lu_done = 1'b1; lu_rd = 5'd3;
        tick();
        idle(); #1;
        check("late_strobe_pending", pending, 0);
        check("late_strobe_full", {31'b0, long_full}, 0);
        instr(1'b1, 5'd5, 1'b0, 5'd0);
        tick();
        check("post_rst_one", {31'b0, long_full}, 0);
        instr(1'b1, 5'd6, 1'b0, 5'd0);
        tick();
        check("post_rst_two", {31'b0, long_full}, 1);
        check("post_rst_pending", pending, 32'h60);
        idle();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
